pipe_flow_ctrl: RTL

- Central flow controller for the 5-stage 32-bit pipeline.
- Each cycle it drives the 2-bit flow op of the PC and of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
- It arbitrates the single-port memory between instruction fetch and the MEM stage, sequences multi-cycle mul/div in EX, and resolves load-use hazards and branch flushes.
- A stall-cycle counter is provided for performance measurement.

---
 rtl/pipe_flow_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: per-stage flow ops, memory port arbitration,
// mul/div sequencing, load-use and flush handling, and a stall counter.
module pipe_flow_ctrl #(
  parameter int MULDIV_CYCLES = 4,
  parameter int MEM_TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  input  logic        if_ack_i,
  input  logic        ex_is_load_i,
  input  logic        ex_wreg_i,
  input  logic [4:0]  ex_wdst_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        id_use_rs_i,
  input  logic        id_use_rt_i,
  input  logic        ex_muldiv_i,
  input  logic        ex_flush_i,
  output logic [1:0]  pc_op_o,
  output logic [1:0]  if_id_op_o,
  output logic [1:0]  id_ex_op_o,
  output logic [1:0]  ex_mem_op_o,
  output logic [1:0]  mem_wb_op_o,
  output logic        mem_grant_o,
  output logic        muldiv_done_o,
  output logic        bus_err_o,
  output logic [31:0] stall_cycles_o
);

  localparam logic [1:0] NORMAL_OP = 2'b00;
  localparam logic [1:0] STALL_OP  = 2'b01;
  localparam logic [1:0] RST_OP    = 2'b10;

  localparam logic [1:0] S_RUN      = 2'b00;
  localparam logic [1:0] S_MEM_WAIT = 2'b01;
  localparam logic [1:0] S_ERROR    = 2'b10;

  localparam int              MDW     = $clog2(MULDIV_CYCLES);
  localparam logic [MDW-1:0]  MD_LOAD = MDW'(MULDIV_CYCLES - 2);
  localparam logic [6:0]      WAIT_LAST = 7'(MEM_TIMEOUT - 1);

  logic [1:0]     state;
  logic [6:0]     wait_cnt;
  logic           md_busy;
  logic [MDW-1:0] md_cnt;
  logic [31:0]    stall_cnt;

  logic in_err, mem_stall, md_start, md_hold, md_done, load_use;

  assign in_err    = (state == S_ERROR);
  assign mem_stall = !in_err && mem_req_i && !mem_ack_i;
  assign md_start  = !in_err && !mem_stall && ex_muldiv_i && !md_busy;
  assign md_hold   = md_busy && (md_cnt != '0);
  assign md_done   = md_busy && (md_cnt == '0) && !mem_stall && !in_err;
  assign load_use  = ex_is_load_i && ex_wreg_i && (ex_wdst_i != 5'd0) &&
                     ((id_use_rs_i && (id_rs_i == ex_wdst_i)) ||
                      (id_use_rt_i && (id_rt_i == ex_wdst_i)));

  assign bus_err_o      = in_err;
  assign stall_cycles_o = stall_cnt;
  assign mem_grant_o    = rst ? 1'b0 : mem_req_i;
  assign muldiv_done_o  = rst ? 1'b0 : md_done;

  always_comb begin
    pc_op_o     = NORMAL_OP;
    if_id_op_o  = NORMAL_OP;
    id_ex_op_o  = NORMAL_OP;
    ex_mem_op_o = NORMAL_OP;
    mem_wb_op_o = NORMAL_OP;
    if (rst) begin
      pc_op_o     = RST_OP;
      if_id_op_o  = RST_OP;
      id_ex_op_o  = RST_OP;
      ex_mem_op_o = RST_OP;
      mem_wb_op_o = RST_OP;
    end else if (in_err) begin
      pc_op_o     = STALL_OP;
      if_id_op_o  = STALL_OP;
      id_ex_op_o  = STALL_OP;
      ex_mem_op_o = STALL_OP;
      mem_wb_op_o = STALL_OP;
    end else if (mem_stall) begin
      pc_op_o     = STALL_OP;
      if_id_op_o  = STALL_OP;
      id_ex_op_o  = STALL_OP;
      ex_mem_op_o = STALL_OP;
      mem_wb_op_o = RST_OP;
    end else begin
      if (md_start || md_hold) begin
        pc_op_o     = STALL_OP;
        if_id_op_o  = STALL_OP;
        id_ex_op_o  = STALL_OP;
        ex_mem_op_o = RST_OP;
      end else if (load_use) begin
        pc_op_o    = STALL_OP;
        if_id_op_o = STALL_OP;
        id_ex_op_o = RST_OP;
      end else if (ex_flush_i) begin
        if_id_op_o = RST_OP;
        id_ex_op_o = RST_OP;
      end
      // Fetch has no port or no data this cycle: hold PC, bubble into ID.
      if ((mem_req_i || !if_ack_i) && (pc_op_o == NORMAL_OP) && !ex_flush_i) begin
        pc_op_o = STALL_OP;
        if (if_id_op_o == NORMAL_OP) if_id_op_o = RST_OP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_RUN;
      wait_cnt <= '0;
    end else if (!in_err) begin
      if (mem_stall) begin
        state    <= (wait_cnt == WAIT_LAST) ? S_ERROR : S_MEM_WAIT;
        wait_cnt <= wait_cnt + 7'd1;
      end else begin
        state    <= S_RUN;
        wait_cnt <= '0;
      end
    end
  end

  // The mul/div countdown keeps running under a memory stall but cannot
  // complete until the stall releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_busy <= 1'b0;
      md_cnt  <= '0;
    end else if (!in_err) begin
      if (md_start) begin
        md_busy <= 1'b1;
        md_cnt  <= MD_LOAD;
      end else if (md_hold) begin
        md_cnt <= md_cnt - 1'b1;
      end else if (md_done) begin
        md_busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((pc_op_o != NORMAL_OP) && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule
